muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the 32-bit ALU. Takes the same A/B operands as the ALU, runs MIPS mult/multu/div/divu (and optionally madd/msub) over multiple cycles, and holds the pipeline with `Busy`. HI/LO feed the EX result mux for mfhi/mflo.

## Interface
- `WIDTH`, 32, operand/HI/LO width; must be 32 for this design.
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  launch operation; sampled only in IDLE
- `Op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 msub; others illegal
- `A`  in  WIDTH  multiplicand / dividend; captured on accepted Start
- `B`  in  WIDTH  multiplier / divisor; captured on accepted Start
- `MtHi`  in  1  write `WData` into HI (mthi)
- `MtLo`  in  1  write `WData` into LO (mtlo)
- `WData`  in  WIDTH  data for mthi/mtlo
- `Busy`  out  1  operation in progress; stall request to hazard logic
- `Done`  out  1  one-cycle pulse: HI/LO just updated by an operation
- `Hi`  out  WIDTH  HI register
- `Lo`  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: `Start`=1 with legal `Op` → capture Op, |A|, |B| (signed ops) or raw A/B (unsigned), result signs, count=31 → CALC. Illegal Op: ignored, stays IDLE.
- CALC: one iteration per cycle, 32 cycles; count decrements, at 0 → FINISH.
  - Multiply: shift-add into 64-bit product.
  - Divide: restoring, one quotient bit per cycle, 32-bit remainder.
- FINISH (1 cycle): apply sign correction; write HI/LO; `Done`←1; → IDLE.
  - mult/multu: {Hi,Lo} = 64-bit product.
  - div/divu: Lo = quotient, Hi = remainder; quotient sign = sign(A)^sign(B), remainder sign = sign(A); truncation toward zero.
  - madd/msub: {Hi,Lo} = {Hi,Lo} ± signed 64-bit product, modulo 2^64, using HI/LO value at FINISH.
- Divide by zero (div or divu): Lo = 32'hFFFFFFFF, Hi = A; same latency, no error flag.
- Signed 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0.
- `Start` while Busy: ignored. Operands not re-sampled during CALC.
- `MtHi`/`MtLo` in IDLE: write at next edge. While Busy: ignored. Same cycle as accepted Start: write applies, later overwritten at FINISH (madd/msub accumulate onto the written value).

## Timing
- Reset (async, low): state IDLE, `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, counters 0. Reset mid-operation aborts; no HI/LO update.
- Start sampled at edge t0 → `Busy` high from t0 to t0+33; FINISH edge t0+33 writes HI/LO, drops `Busy`, raises `Done` for exactly one cycle (t0+33 to t0+34).
- Fixed 33-cycle latency from accepting edge to HI/LO valid, for all ops and operand values.
- Back-to-back: new `Start` may be accepted at t0+33 edge's following cycle (state IDLE while `Done` high). Next accepted edge is t0+34.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `MULDIV_MADD_EN` defined: Op 100/101 (madd/msub) supported as above.
- Not defined: Op 100/101 illegal. Start ignored, no Busy, HI/LO unchanged. Accumulate adder removed.

## Test plan
- mult A=0xFFFFFFFD (-3), B=7, Start at t0 → Busy t0..t0+33; Done pulse at t0+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- multu A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001; then div A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- divu A=0x12345678, B=0 → Lo=0xFFFFFFFF, Hi=0x12345678 after 33 cycles; signed 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- With `MULDIV_MADD_EN`: mthi 0, mtlo 10, madd A=3 B=4 → Lo=22; msub A=5 B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFD. Without macro: Op=100 Start → Busy stays 0, HI/LO unchanged.
- Start mult 2×3, then Start div and MtHi(0xDEAD) pulsed at cycle 10 → both ignored; result Hi=0, Lo=6.
- Start mult, drive Reset low at cycle 15 → Busy=0, Done=0, Hi=Lo=0 immediately; no Done after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with HI/LO registers (33-cycle fixed latency).
// Define MULDIV_MADD_EN to enable madd/msub (Op 100/101) and the HI/LO accumulate adder.
//   state  | meaning
//   IDLE   | waiting for Start; mthi/mtlo accepted
//   CALC   | one shift-add or restoring-divide step per cycle, 32 steps
//   FINISH | sign correction, HI/LO write, Done pulse
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MtHi,
   input  logic             MtLo,
   input  logic [WIDTH-1:0] WData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
   state_t state_q, state_d;

   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, acc_q, wrk_q, hi_q, lo_q;
   logic [CW-1:0]      cnt_q;
   logic               a_neg_q, res_neg_q, busy_q, done_q;

   logic               legal, accept, in_signed, in_div, a_sgn, b_sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_mag, prod_s;
   logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

   always_comb begin
`ifdef MULDIV_MADD_EN
      legal = ~Op[2] | (Op[2:1] == 2'b10);
`else
      legal = ~Op[2];
`endif
      accept    = (state_q == S_IDLE) & Start & legal;
      in_signed = ~Op[0] | Op[2];
      in_div    = ~Op[2] & Op[1];
      a_sgn     = in_signed & A[WIDTH-1];
      b_sgn     = in_signed & B[WIDTH-1];
      a_mag     = a_sgn ? -A : A;
      b_mag     = b_sgn ? -B : B;
   end

   // Multiply: multiplier sits in wrk_q and shifts right as the product fills in from the top.
   // Divide: dividend sits in wrk_q, shifts left into acc_q while quotient bits enter at bit 0.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? a_q : '0)};
      div_shift = {acc_q, wrk_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_CALC;
         S_CALC:   if (cnt_q == '0) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      prod_mag        = {acc_q, wrk_q};
      prod_s          = res_neg_q ? -prod_mag : prod_mag;
      quot            = res_neg_q ? -wrk_q : wrk_q;
      rem             = a_neg_q ? -acc_q : acc_q;
      {res_hi, res_lo} = prod_s;
      case (op_q)
         // A zero divisor yields all-ones quotient bits and rem = |A|, so only Lo needs forcing.
         3'b010, 3'b011: begin
            res_hi = rem;
            res_lo = (b_q == '0) ? '1 : quot;
         end
`ifdef MULDIV_MADD_EN
         3'b100: {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
         3'b101: {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         wrk_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         a_neg_q   <= 1'b0;
         res_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_q == S_FINISH);
         if (accept) begin
            op_q      <= Op;
            a_q       <= a_mag;
            b_q       <= b_mag;
            a_neg_q   <= a_sgn;
            res_neg_q <= a_sgn ^ b_sgn;
            cnt_q     <= CW'(WIDTH - 1);
            acc_q     <= '0;
            wrk_q     <= in_div ? a_mag : b_mag;
         end else if (state_q == S_CALC) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if ((op_q == 3'b010) || (op_q == 3'b011)) begin
               if (!div_diff[WIDTH]) begin
                  acc_q <= div_diff[WIDTH-1:0];
                  wrk_q <= {wrk_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_q <= div_shift[WIDTH-1:0];
                  wrk_q <= {wrk_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               {acc_q, wrk_q} <= {mul_sum, wrk_q[WIDTH-1:1]};
            end
         end
         if (state_q == S_IDLE) begin
            if (MtHi) hi_q <= WData;
            if (MtLo) lo_q <= WData;
         end else if (state_q == S_FINISH) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule
